instr_align_buffer: RTL
=======================

// Module: instr_align_buffer
// PURPOSE
//  Halfword-granular fetch queue between Fetch and the IFID/Decode stage. Accepts
//  64-bit fetch packets, realigns mixed 16/32-bit RISC-V instructions and presents
//  up to two in-order instructions with their PCs to the dual-issue decoder.
//  Absorbs instructions straddling packet boundaries. Decode frees entries by count.
// PARAMETERS
//  DEPTH_HW  16            queue depth in 16-bit parcels; power of 2, >= 8
//  PC_W      32            PC width
//  NOP_INSTR 32'h00000013  value driven on an invalid slot
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     asynchronous active-low reset
//  Flush          in   1     drop all buffered parcels (redirect/exception)
//  Fetch_Valid    in   1     fetch packet valid
//  Fetch_Ready    out  1     buffer can accept a full packet
//  Fetch_PC       in   PC_W  PC of packet; [2:1] = first live halfword
//  Fetch_Data     in   64    packet, halfword 0 in bits [15:0]
//  Decode_Accept  in   2     slots consumed this cycle (0,1,2), in order
//  IFID_Instr     out  64    {slot1, slot0}; 16-bit instr zero-extended to 32
//  IFID_NowPC_0   out  PC_W  PC of slot0
//  IFID_NowPC_1   out  PC_W  PC of slot1
//  Slot_Valid     out  2     per-slot valid
//  Slot_16Bit     out  2     per-slot compressed flag
//  Buf_Count      out  $clog2(DEPTH_HW)+1  parcels held
// BEHAVIOUR
//  - State: parcel RAM[DEPTH_HW], rd_ptr, wr_ptr (wrap mod DEPTH_HW), count, head_pc.
//  - Reset: ptrs/count/head_pc = 0; Slot_Valid=0; IFID_Instr={NOP,NOP}; PCs=0; Fetch_Ready=1.
//  - Fetch_Ready = !Flush && (count <= DEPTH_HW-4); uses current count, not same-cycle pops.
//  - Write (Fetch_Valid&&Fetch_Ready): parcels Fetch_PC[2:1]..3 stored, n_wr = 4-Fetch_PC[2:1].
//    If count==0 at write, head_pc <= {Fetch_PC[PC_W-1:1],1'b0}. Packets are sequential
//    between flushes; no PC check.
//  - Slot0 decode (combinational from registers): p0=RAM[rd_ptr]; 16-bit if p0[1:0]!=2'b11.
//    Valid if (16-bit && count>=1) || count>=2. Slot0 length L0 = 1 or 2 parcels.
//  - Slot1: starts at rd_ptr+L0, same rule on remaining count; valid only if slot0 valid.
//    IFID_NowPC_0 = head_pc; IFID_NowPC_1 = head_pc + 2*L0.
//  - Invalid slot: instr = NOP_INSTR, 16Bit=0, PC still driven.
//  - Latency: packet written at edge N is visible at outputs after edge N.
//  - Pop: eff = min(Decode_Accept, leading valid slots); pop parcels of accepted slots;
//    head_pc += 2*popped. Accept beyond valid slots is clamped, never underflows.
//  - Simultaneous write+pop: count <= count + n_wr - popped; both pointers advance.
//  - Half-instruction at tail (upper parcel of 32-bit not yet fetched): slot invalid, waits.
//  - Flush (sync, highest priority): rd_ptr=wr_ptr=count=0; same-cycle write and pop dropped;
//    head_pc reloaded by next write.
//  - Reset asserted mid-operation clears everything asynchronously; no partial state kept.
// CONFIGURATION
//  IAB_RVC_EN defined: compressed detection as above.
//  IAB_RVC_EN undefined: every slot is 32-bit (L0=2), Slot_16Bit=0, Fetch_PC[1] treated as 0,
//  n_wr = 4-2*Fetch_PC[2]; a 16-bit encoding is passed through as 32-bit (decode traps).
// TESTING
//  1 Reset, write PC=0x0 data 64'h57c157c1_00000013 -> slot0=0x00000013 PC 0x0 32b,
//    slot1=0x000057c1 PC 0x4 16b, Buf_Count=4.
//  2 Then Accept=2 -> slot0=0x000057c1 PC 0x6 16b, Slot_Valid=01, Buf_Count=1.
//  3 Write PC=0x6 data lane3=0x0013 -> slot0=0x13 lower half only, Slot_Valid=00 until next
//    packet 0x0000 at PC 0x8 lands -> slot0=0x00000013 PC 0x6.
//  4 Fill to 13 parcels -> Fetch_Ready=0; Accept=2 of 16b slots same cycle as Fetch_Valid ->
//    no write; next cycle Fetch_Ready=1, pointers wrap past 15 without data corruption.
//  5 Flush with Fetch_Valid=1, Accept=2 -> Buf_Count=0, Slot_Valid=00, packet dropped.
//  6 Build without IAB_RVC_EN, data 64'h57c157c1_00000013 -> slot1=0x57c157c1 32b PC 0x4.

Source files
------------

// File: rtl/instr_align_buffer_if.sv
// Fetch/decode bus of the instruction align buffer: fetch packet in, two decoded slots out.
interface instr_align_buffer_if #(
  parameter int unsigned DEPTH_HW = 16,
  parameter int unsigned PC_W     = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH_HW) + 1;

  logic              Flush;
  logic              Fetch_Valid;
  logic              Fetch_Ready;
  logic [PC_W-1:0]   Fetch_PC;
  logic [63:0]       Fetch_Data;
  logic [1:0]        Decode_Accept;
  logic [63:0]       IFID_Instr;
  logic [PC_W-1:0]   IFID_NowPC_0;
  logic [PC_W-1:0]   IFID_NowPC_1;
  logic [1:0]        Slot_Valid;
  logic [1:0]        Slot_16Bit;
  logic [CNT_W-1:0]  Buf_Count;

  // Fetch/decode side of the buffer
  modport master (
    output Flush, Fetch_Valid, Fetch_PC, Fetch_Data, Decode_Accept,
    input  Fetch_Ready, IFID_Instr, IFID_NowPC_0, IFID_NowPC_1,
           Slot_Valid, Slot_16Bit, Buf_Count
  );

  // The buffer itself
  modport slave (
    input  Flush, Fetch_Valid, Fetch_PC, Fetch_Data, Decode_Accept,
    output Fetch_Ready, IFID_Instr, IFID_NowPC_0, IFID_NowPC_1,
           Slot_Valid, Slot_16Bit, Buf_Count
  );
endinterface

// File: rtl/instr_align_buffer.sv
// Halfword-granular fetch queue realigning 16/32-bit instructions into two decode slots.
// Define IAB_RVC_EN to enable compressed (16-bit) instruction detection.
module instr_align_buffer #(
  parameter int unsigned DEPTH_HW  = 16,
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_align_buffer_if.slave  io_bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH_HW);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HW_W  = 16;

  logic [HW_W-1:0]  r_ram [DEPTH_HW];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_head_pc;

  logic [HW_W-1:0]  w_p0, w_p1, w_p2, w_p3;
  logic [HW_W-1:0]  w_q0, w_q1;
  logic             w_s0_16, w_s1_16;
  logic             w_s0_valid, w_s1_valid;
  logic [CNT_W-1:0] w_l0, w_l1, w_rem, w_pop, w_n_wr;
  logic [1:0]       w_lane0;
  logic [PC_W-1:0]  w_wr_pc;
  logic             w_ready, w_wr_en;
  logic [3:0]       w_wr_lane;
  logic [PTR_W-1:0] w_wr_idx [4];
  logic [31:0]      w_s0_instr, w_s1_instr;
  logic             w_unused_ok;

  // Look-ahead window of four parcels from the head
  assign w_p0 = r_ram[r_rd_ptr];
  assign w_p1 = r_ram[PTR_W'(r_rd_ptr + PTR_W'(1))];
  assign w_p2 = r_ram[PTR_W'(r_rd_ptr + PTR_W'(2))];
  assign w_p3 = r_ram[PTR_W'(r_rd_ptr + PTR_W'(3))];

  assign w_q0 = w_s0_16 ? w_p1 : w_p2;
  assign w_q1 = w_s0_16 ? w_p2 : w_p3;

`ifdef IAB_RVC_EN
  assign w_s0_16 = (w_p0[1:0] != 2'b11);
  assign w_s1_16 = (w_q0[1:0] != 2'b11);
  assign w_lane0 = io_bus.Fetch_PC[2:1];
  assign w_wr_pc = {io_bus.Fetch_PC[PC_W-1:1], 1'b0};
`else
  assign w_s0_16 = 1'b0;
  assign w_s1_16 = 1'b0;
  assign w_lane0 = {io_bus.Fetch_PC[2], 1'b0};
  assign w_wr_pc = {io_bus.Fetch_PC[PC_W-1:2], 2'b00};
`endif
  assign w_unused_ok = ^io_bus.Fetch_PC[1:0];

  // Slot lengths and validity; slot1 only counts parcels left after slot0
  assign w_l0       = w_s0_16 ? CNT_W'(1) : CNT_W'(2);
  assign w_l1       = w_s1_16 ? CNT_W'(1) : CNT_W'(2);
  assign w_s0_valid = (w_s0_16 && (r_count >= CNT_W'(1))) || (r_count >= CNT_W'(2));
  assign w_rem      = r_count - w_l0;
  assign w_s1_valid = w_s0_valid &&
                      ((w_s1_16 && (w_rem >= CNT_W'(1))) || (w_rem >= CNT_W'(2)));

  // Accept is clamped to the leading valid slots
  always_comb begin
    w_pop = '0;
    if ((io_bus.Decode_Accept != 2'b00) && w_s0_valid) begin
      w_pop = w_l0;
      if (io_bus.Decode_Accept[1] && w_s1_valid) begin
        w_pop = w_l0 + w_l1;
      end
    end
  end

  assign w_ready = !io_bus.Flush && (r_count <= CNT_W'(DEPTH_HW - 4));
  assign w_wr_en = io_bus.Fetch_Valid && w_ready;
  assign w_n_wr  = CNT_W'(4) - CNT_W'(w_lane0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_wr_lane[i] = w_wr_en && (2'(i) >= w_lane0);
      w_wr_idx[i]  = PTR_W'(r_wr_ptr + PTR_W'(i) - PTR_W'(w_lane0));
    end
  end

  // Queue state; flush wins over any same-cycle write or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_HW; i++) begin
        r_ram[i] <= '0;
      end
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_head_pc <= '0;
    end else if (io_bus.Flush) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_head_pc <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_lane[i]) begin
          r_ram[w_wr_idx[i]] <= io_bus.Fetch_Data[i*HW_W +: HW_W];
        end
      end
      if (w_wr_en) begin
        r_wr_ptr <= PTR_W'(r_wr_ptr + PTR_W'(w_n_wr));
      end
      r_rd_ptr <= PTR_W'(r_rd_ptr + PTR_W'(w_pop));
      r_count  <= r_count + (w_wr_en ? w_n_wr : CNT_W'(0)) - w_pop;
      if (w_wr_en && (r_count == '0)) begin
        r_head_pc <= w_wr_pc;
      end else begin
        r_head_pc <= r_head_pc + PC_W'({w_pop, 1'b0});
      end
    end
  end

  assign w_s0_instr = w_s0_16 ? {16'h0000, w_p0} : {w_p1, w_p0};
  assign w_s1_instr = w_s1_16 ? {16'h0000, w_q0} : {w_q1, w_q0};

  assign io_bus.Fetch_Ready  = w_ready;
  assign io_bus.IFID_Instr   = {(w_s1_valid ? w_s1_instr : NOP_INSTR),
                                (w_s0_valid ? w_s0_instr : NOP_INSTR)};
  assign io_bus.IFID_NowPC_0 = r_head_pc;
  // With nothing buffered there is no slot0 length, so both PCs sit at the head
  assign io_bus.IFID_NowPC_1 = (r_count == '0) ? r_head_pc
                                                : r_head_pc + PC_W'({w_l0, 1'b0});
  assign io_bus.Slot_Valid   = {w_s1_valid, w_s0_valid};
  assign io_bus.Slot_16Bit   = {w_s1_valid && w_s1_16, w_s0_valid && w_s0_16};
  assign io_bus.Buf_Count    = r_count;

endmodule
